// File: rtl/tx_write_arbiter_if.sv
// TX FIFO write-side bundle shared by host, control unit and arbiter.
// master drives requests, slave is the arbiter.
interface tx_write_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] host_data_i;
  logic                  host_valid_i;
  logic                  host_ready_o;
  logic [DATA_WIDTH-1:0] cfg_data_i;
  logic                  cfg_write_i;
  logic                  cfg_busy_o;
  logic                  cfg_overrun_o;
  logic                  cfg_lock_req_i;
  logic                  cfg_lock_ack_o;
  logic                  tx_fifo_full_i;
  logic                  tx_fifo_write_o;
  logic [DATA_WIDTH-1:0] tx_fifo_data_o;

  modport master (
    output host_data_i, host_valid_i,
    output cfg_data_i, cfg_write_i,
    output cfg_lock_req_i, tx_fifo_full_i,
    input  host_ready_o, cfg_busy_o,
    input  cfg_overrun_o, cfg_lock_ack_o,
    input  tx_fifo_write_o, tx_fifo_data_o
  );

  modport slave (
    input  host_data_i, host_valid_i,
    input  cfg_data_i, cfg_write_i,
    input  cfg_lock_req_i, tx_fifo_full_i,
    output host_ready_o, cfg_busy_o,
    output cfg_overrun_o, cfg_lock_ack_o,
    output tx_fifo_write_o, tx_fifo_data_o
  );
endinterface

// File: rtl/tx_write_arbiter.sv
// TX FIFO write-port arbiter: host vs. control-unit config traffic,
// config priority with host starvation limit and a drain/lock handshake.
module tx_write_arbiter #(
  parameter int DATA_WIDTH        = 8,
  parameter int HOST_STARVE_LIMIT = 4
) (
  input logic               clk_i,
  input logic               rst_n_i,
  tx_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    DRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } buf_t;

  localparam logic [3:0] LIMIT = 4'(HOST_STARVE_LIMIT);

  state_e     state_q, state_d;
  buf_t       host_q, cfg_q;
  logic [3:0] starve_q;
  logic       ack_q;
  logic       ovr_q;

  logic host_win, cfg_win;
  logic host_ready, cfg_busy;
  logic host_acc, cfg_acc;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= OPEN;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == LOCKED);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OPEN:
        if (bus.cfg_lock_req_i) state_d = DRAIN;
      DRAIN:
        if (!bus.cfg_lock_req_i)
          state_d = OPEN;
        else if (!host_q.valid || host_win)
          state_d = LOCKED;
      LOCKED:
        if (!bus.cfg_lock_req_i) state_d = OPEN;
      default:
        state_d = OPEN;
    endcase
  end

  // Nothing wins while the FIFO is full, so buffers and counter hold.
  always_comb begin
    host_win = 1'b0;
    cfg_win  = 1'b0;
    if (!bus.tx_fifo_full_i) begin
      host_win = host_q.valid
               & (!cfg_q.valid
                  | (state_q == DRAIN)
                  | ((state_q == OPEN) & (starve_q == LIMIT)));
      cfg_win  = cfg_q.valid & !host_win;
    end
    host_ready = (state_q == OPEN) & (!host_q.valid | host_win);
    cfg_busy   = cfg_q.valid & !cfg_win;
  end

  assign host_acc = bus.host_valid_i & host_ready;
  assign cfg_acc  = bus.cfg_write_i & !cfg_busy;

  assign bus.host_ready_o    = host_ready;
  assign bus.cfg_busy_o      = cfg_busy;
  assign bus.cfg_overrun_o   = ovr_q;
  assign bus.cfg_lock_ack_o  = ack_q;
  assign bus.tx_fifo_write_o = host_win | cfg_win;
  assign bus.tx_fifo_data_o  = host_win ? host_q.data
                             : cfg_win  ? cfg_q.data
                             : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      host_q   <= '0;
      cfg_q    <= '0;
      starve_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (host_acc)
        host_q <= '{valid: 1'b1, data: bus.host_data_i};
      else if (host_win)
        host_q.valid <= 1'b0;

      if (cfg_acc)
        cfg_q <= '{valid: 1'b1, data: bus.cfg_data_i};
      else if (cfg_win)
        cfg_q.valid <= 1'b0;

      ovr_q <= bus.cfg_write_i & cfg_busy;

      if (!bus.tx_fifo_full_i) begin
        if (host_win || !host_q.valid)
          starve_q <= '0;
        else if (cfg_win && starve_q != LIMIT)
          starve_q <= starve_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_tx_write_arbiter.sv
// Directed bench for tx_write_arbiter: streaming, starvation limit,
// lock/drain handshake, overrun and mid-operation reset.
module tb_tx_write_arbiter;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  tx_write_arbiter #(
    .DATA_WIDTH(DW),
    .HOST_STARVE_LIMIT(4)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  bit         saw_ovr;
  bit         saw_ack;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe FIFO side well clear of both clock edges.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.tx_fifo_write_o === 1'b1) begin
      wr_data.push_back(bus.tx_fifo_data_o);
      wr_cyc.push_back(cyc);
    end
    if (bus.cfg_overrun_o === 1'b1) saw_ovr = 1'b1;
    if (bus.cfg_lock_ack_o === 1'b1) saw_ack = 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.host_data_i    = '0;
    bus.host_valid_i   = 1'b0;
    bus.cfg_data_i     = '0;
    bus.cfg_write_i    = 1'b0;
    bus.cfg_lock_req_i = 1'b0;
    bus.tx_fifo_full_i = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.tx_fifo_write_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_write got=%b exp=0", bus.tx_fifo_write_o);
    end
    checks++;
    if (bus.tx_fifo_data_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h exp=00", bus.tx_fifo_data_o);
    end
    checks++;
    if (bus.cfg_lock_ack_o !== 1'b0 || bus.cfg_overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack_ovr got=%b%b exp=00",
               bus.cfg_lock_ack_o, bus.cfg_overrun_o);
    end
    checks++;
    if (bus.host_ready_o !== 1'b1 || bus.cfg_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_busy got=%b%b exp=10",
               bus.host_ready_o, bus.cfg_busy_o);
    end
  endtask

  task automatic test_stream();
    int acc[8];
    wr_data.delete();
    wr_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.host_valid_i = 1'b1;
      bus.host_data_i  = 8'(i + 1);
      acc[i] = cyc;
      #1;
      checks++;
      if (bus.host_ready_o !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d] got=%b exp=1", i, bus.host_ready_o);
      end
    end
    @(negedge clk);
    bus.host_valid_i = 1'b0;
    idle(2);
    checks++;
    if (wr_data.size() != 8) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=8", wr_data.size());
    end
    for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== 8'(i + 1) || wr_cyc[i] != acc[i] + 1) begin
        failures++;
        $display("FAIL stream_byte[%0d] got=%h@%0d exp=%h@%0d",
                 i, wr_data[i], wr_cyc[i], 8'(i + 1), acc[i] + 1);
      end
    end
  endtask

  task automatic test_starve();
    logic [7:0] exp[7] = '{8'h16, 8'h17, 8'h18, 8'h19,
                           8'hAA, 8'h1A, 8'h1B};
    int sent;
    int guard;
    wr_data.delete();
    wr_cyc.delete();
    saw_ovr = 1'b0;
    @(negedge clk);
    bus.tx_fifo_full_i = 1'b1;
    bus.host_valid_i   = 1'b1;
    bus.host_data_i    = 8'hAA;
    bus.cfg_write_i    = 1'b1;
    bus.cfg_data_i     = 8'h16;
    sent  = 1;
    guard = 0;
    @(negedge clk);
    bus.host_valid_i   = 1'b0;
    bus.cfg_write_i    = 1'b0;
    bus.tx_fifo_full_i = 1'b0;
    while (sent < 6 && guard < 20) begin
      #1;
      if (!bus.cfg_busy_o) begin
        bus.cfg_write_i = 1'b1;
        bus.cfg_data_i  = 8'(8'h16 + sent);
        sent++;
      end
      @(negedge clk);
      bus.cfg_write_i = 1'b0;
      guard++;
    end
    idle(4);
    checks++;
    if (sent != 6 || wr_data.size() != 7) begin
      failures++;
      $display("FAIL starve_count sent=%0d writes=%0d exp=6,7",
               sent, wr_data.size());
    end
    for (int i = 0; i < 7 && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL starve_order[%0d] got=%h exp=%h",
                 i, wr_data[i], exp[i]);
      end
    end
    checks++;
    if (saw_ovr !== 1'b0) begin
      failures++;
      $display("FAIL starve_overrun got=1 exp=0");
    end
  endtask

  task automatic test_lock_drain();
    logic [7:0] exp[4] = '{8'h55, 8'h16, 8'h16, 8'h16};
    wr_data.delete();
    wr_cyc.delete();
    @(negedge clk);
    bus.tx_fifo_full_i = 1'b1;
    bus.host_valid_i   = 1'b1;
    bus.host_data_i    = 8'h55;
    @(negedge clk);
    bus.host_valid_i   = 1'b0;
    bus.cfg_lock_req_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.cfg_lock_ack_o !== 1'b0 || bus.host_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold[%0d] ack/ready got=%b%b exp=00",
                 i, bus.cfg_lock_ack_o, bus.host_ready_o);
      end
    end
    bus.tx_fifo_full_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.cfg_lock_ack_o !== 1'b1 || bus.host_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL lock_entry ack/ready got=%b%b exp=10",
               bus.cfg_lock_ack_o, bus.host_ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      bus.cfg_write_i = 1'b1;
      bus.cfg_data_i  = 8'h16;
      @(negedge clk);
    end
    bus.cfg_write_i = 1'b0;
    idle(3);
    checks++;
    if (wr_data.size() != 4) begin
      failures++;
      $display("FAIL lock_count got=%0d exp=4", wr_data.size());
    end
    for (int i = 0; i < 4 && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== exp[i]) begin
        failures++;
        $display("FAIL lock_order[%0d] got=%h exp=%h",
                 i, wr_data[i], exp[i]);
      end
    end
    bus.cfg_lock_req_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.cfg_lock_ack_o !== 1'b0 || bus.host_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL unlock ack/ready got=%b%b exp=01",
               bus.cfg_lock_ack_o, bus.host_ready_o);
    end
  endtask

  task automatic test_overrun();
    wr_data.delete();
    wr_cyc.delete();
    @(negedge clk);
    bus.cfg_lock_req_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.cfg_lock_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL ack_early got=%b exp=0", bus.cfg_lock_ack_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.cfg_lock_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL ack_two_cycles got=%b exp=1", bus.cfg_lock_ack_o);
    end
    bus.tx_fifo_full_i = 1'b1;
    bus.cfg_write_i    = 1'b1;
    bus.cfg_data_i     = 8'h30;
    @(negedge clk);
    bus.cfg_data_i = 8'h31;
    #1;
    checks++;
    if (bus.cfg_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL ovr_busy got=%b exp=1", bus.cfg_busy_o);
    end
    @(negedge clk);
    bus.cfg_write_i = 1'b0;
    #1;
    checks++;
    if (bus.cfg_overrun_o !== 1'b1 || bus.cfg_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL ovr_pulse ovr/busy got=%b%b exp=11",
               bus.cfg_overrun_o, bus.cfg_busy_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.cfg_overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL ovr_one_cycle got=%b exp=0", bus.cfg_overrun_o);
    end
    bus.tx_fifo_full_i = 1'b0;
    idle(3);
    checks++;
    if (wr_data.size() != 1 || wr_data[0] !== 8'h30) begin
      failures++;
      $display("FAIL ovr_kept writes=%0d first=%h exp=1,30",
               wr_data.size(), wr_data.size() > 0 ? wr_data[0] : 8'h00);
    end
    bus.cfg_lock_req_i = 1'b0;
    idle(2);
  endtask

  task automatic test_drain_abort();
    wr_data.delete();
    wr_cyc.delete();
    saw_ack = 1'b0;
    @(negedge clk);
    bus.tx_fifo_full_i = 1'b1;
    bus.host_valid_i   = 1'b1;
    bus.host_data_i    = 8'h77;
    @(negedge clk);
    bus.host_valid_i   = 1'b0;
    bus.cfg_lock_req_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.host_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_drain_ready got=%b exp=0", bus.host_ready_o);
    end
    bus.cfg_lock_req_i = 1'b0;
    bus.tx_fifo_full_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.host_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL abort_open_ready got=%b exp=1", bus.host_ready_o);
    end
    idle(2);
    checks++;
    if (saw_ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_ack got=1 exp=0");
    end
    checks++;
    if (wr_data.size() != 1 || wr_data[0] !== 8'h77) begin
      failures++;
      $display("FAIL abort_write writes=%0d first=%h exp=1,77",
               wr_data.size(), wr_data.size() > 0 ? wr_data[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.cfg_lock_req_i = 1'b1;
    idle(2);
    bus.tx_fifo_full_i = 1'b1;
    bus.cfg_write_i    = 1'b1;
    bus.cfg_data_i     = 8'h44;
    @(negedge clk);
    bus.cfg_write_i    = 1'b0;
    bus.host_valid_i   = 1'b1;
    bus.host_data_i    = 8'h99;
    bus.tx_fifo_full_i = 1'b0;
    #1;
    checks++;
    if (bus.tx_fifo_write_o !== 1'b1 || bus.tx_fifo_data_o !== 8'h44
        || bus.cfg_lock_ack_o !== 1'b1) begin
      failures++;
      $display("FAIL prereset wr/data/ack got=%b/%h/%b exp=1/44/1",
               bus.tx_fifo_write_o, bus.tx_fifo_data_o, bus.cfg_lock_ack_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.tx_fifo_write_o !== 1'b0 || bus.tx_fifo_data_o !== 8'h00
        || bus.cfg_lock_ack_o !== 1'b0 || bus.cfg_overrun_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset wr/data/ack/ovr got=%b/%h/%b/%b exp=0/00/0/0",
               bus.tx_fifo_write_o, bus.tx_fifo_data_o,
               bus.cfg_lock_ack_o, bus.cfg_overrun_o);
    end
    @(negedge clk);
    bus.host_valid_i   = 1'b0;
    bus.cfg_lock_req_i = 1'b0;
    rst_n = 1'b1;
    wr_data.delete();
    wr_cyc.delete();
    idle(3);
    checks++;
    if (wr_data.size() != 0) begin
      failures++;
      $display("FAIL postreset_stale writes=%0d exp=0", wr_data.size());
    end
    checks++;
    if (bus.host_ready_o !== 1'b1 || bus.cfg_lock_ack_o !== 1'b0) begin
      failures++;
      $display("FAIL postreset ready/ack got=%b%b exp=10",
               bus.host_ready_o, bus.cfg_lock_ack_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_starve();
    test_lock_drain();
    test_overrun();
    test_drain_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
